rr_run_scheduler: RTL and testbench

RR_RUN_SCHEDULER -- requirements
Module: rr_run_scheduler

---
 rtl/rr_run_scheduler.sv | 119 +++++++++++
 tb/tb_rr_run_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_run_scheduler.sv
// Round-robin run-slot scheduler: grants one requester the shared engine for cfg_len RUN cycles plus one WAIT, then DONE.
// Grant one edge after req is seen in IDLE; no backpressure, the winner's req level alone holds or abandons the slot.
module rr_run_scheduler #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [CNT_W-1:0] cfg_len,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             abort
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] pick;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             abort_q, abort_d;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick = ptr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int               j;
            logic [IDX_W-1:0] jj;
            j = int'(ptr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            jj = IDX_W'(j);
            if (req[jj]) pick = jj;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        len_d   = len_q;
        count_d = count_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                abort_d = 1'b0;
                if (|req) begin
                    win_d   = pick;
                    len_d   = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Reaching the last cycle wins over a req drop seen on the same edge.
                if (count_q == len_q - CNT_W'(1)) begin
                    state_d = WAIT;
                end else if (!req[win_q]) begin
                    state_d = DONE;
                    abort_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            WAIT: state_d = DONE;
            DONE: begin
                ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                count_d = '0;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                count_d = '0;
                abort_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            len_q   <= CNT_W'(1);
            count_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            len_q   <= len_d;
            count_q <= count_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == RUN || state_q == WAIT) grant[win_q] = 1'b1;
    end

    assign state = state_q;
    assign count = count_q;
    assign done  = (state_q == DONE);
    assign abort = (state_q == DONE) && abort_q;

endmodule

// File: tb/tb_rr_run_scheduler.sv
// Directed bench for rr_run_scheduler: per-cycle vector table plus a hand-written mid-slot reset sequence.
module tb_rr_run_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'h0;
    logic [7:0] cfg_len = 8'd0;
    logic [3:0] grant;
    logic [1:0] state;
    logic [7:0] count;
    logic       done;
    logic       abort;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] I = 2'd0, R = 2'd1, W = 2'd2, D = 2'd3;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [7:0] len;
        logic [3:0] grant;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       done;
        logic       abort;
    } vec_t;

    vec_t vecs[$];

    rr_run_scheduler #(.N_REQ(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .cfg_len (cfg_len),
        .grant   (grant),
        .state   (state),
        .count   (count),
        .done    (done),
        .abort   (abort)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] q, input logic [7:0] l,
                       input logic [3:0] g, input logic [1:0] s, input logic [7:0] c,
                       input logic d, input logic a);
        vec_t v;
        v.rst_n = r; v.req = q; v.len = l;
        v.grant = g; v.st = s; v.cnt = c; v.done = d; v.abort = a;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (grant,state,count,done,abort)", name, got, exp);
        end
    endtask

    initial begin
        // Single requester, length 3; first grant on first edge with req set.
        add(1'b0, 4'h0, 8'd3, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd3, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h1, 8'd3, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h1, 8'd3, 4'h1, R, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h1, 8'd3, 4'h1, R, 8'd1, 1'b0, 1'b0);
        add(1'b1, 4'h1, 8'd3, 4'h1, R, 8'd2, 1'b0, 1'b0);
        add(1'b1, 4'h1, 8'd3, 4'h1, W, 8'd2, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd3, 4'h0, D, 8'd2, 1'b1, 1'b0);
        add(1'b1, 4'h0, 8'd3, 4'h0, I, 8'd0, 1'b0, 1'b0);
        // All four requesting, length 1: rotation 0001,0010,0100,1000,0001.
        add(1'b0, 4'hF, 8'd1, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'hF, 8'd1, 4'h0, I, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            add(1'b1, 4'hF, 8'd1, 4'(1 << k), R, 8'd0, 1'b0, 1'b0);
            add(1'b1, 4'hF, 8'd1, 4'(1 << k), W, 8'd0, 1'b0, 1'b0);
            add(1'b1, 4'hF, 8'd1, 4'h0,       D, 8'd0, 1'b1, 1'b0);
            add(1'b1, 4'hF, 8'd1, 4'h0,       I, 8'd0, 1'b0, 1'b0);
        end
        add(1'b1, 4'hF, 8'd1, 4'h1, R, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'hF, 8'd1, 4'h1, W, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'hF, 8'd1, 4'h0, D, 8'd0, 1'b1, 1'b0);
        // Early end: req[0] dropped after two RUN cycles, then requester 2 gets a full slot.
        add(1'b0, 4'h5, 8'd4, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h5, 8'd4, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h5, 8'd4, 4'h1, R, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h5, 8'd4, 4'h1, R, 8'd1, 1'b0, 1'b0);
        add(1'b1, 4'h4, 8'd4, 4'h1, R, 8'd2, 1'b0, 1'b0);
        add(1'b1, 4'h4, 8'd4, 4'h0, D, 8'd2, 1'b1, 1'b1);
        add(1'b1, 4'h4, 8'd4, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h4, 8'd4, 4'h4, R, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h4, 8'd4, 4'h4, R, 8'd1, 1'b0, 1'b0);
        add(1'b1, 4'h4, 8'd4, 4'h4, R, 8'd2, 1'b0, 1'b0);
        add(1'b1, 4'h4, 8'd4, 4'h4, R, 8'd3, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd4, 4'h4, W, 8'd3, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd4, 4'h0, D, 8'd3, 1'b1, 1'b0);
        add(1'b1, 4'h0, 8'd4, 4'h0, I, 8'd0, 1'b0, 1'b0);
        // req drops on the last RUN cycle: normal end, no abort. ptr=3 wraps to requester 1.
        add(1'b1, 4'h2, 8'd2, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h2, 8'd2, 4'h2, R, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd2, 4'h2, R, 8'd1, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd2, 4'h2, W, 8'd1, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd2, 4'h0, D, 8'd1, 1'b1, 1'b0);
        add(1'b1, 4'h0, 8'd2, 4'h0, I, 8'd0, 1'b0, 1'b0);
        // cfg_len=0 behaves as 1.
        add(1'b1, 4'h1, 8'd0, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h1, 8'd0, 4'h1, R, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd0, 4'h1, W, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd0, 4'h0, D, 8'd0, 1'b1, 1'b0);
        add(1'b1, 4'h0, 8'd0, 4'h0, I, 8'd0, 1'b0, 1'b0);
        // cfg_len=255: 255 RUN cycles, count tops out at 254.
        add(1'b1, 4'h2, 8'd255, 4'h0, I, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 255; k++)
            add(1'b1, 4'h2, 8'd255, 4'h2, R, 8'(k), 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd255, 4'h2, W, 8'd254, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd255, 4'h0, D, 8'd254, 1'b1, 1'b0);
        add(1'b1, 4'h0, 8'd255, 4'h0, I, 8'd0,   1'b0, 1'b0);
        // cfg_len and other req bits change mid-slot; next slot picks up length 9.
        add(1'b1, 4'h4, 8'd3, 4'h0, I, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'h4, 8'd9, 4'h4, R, 8'd0, 1'b0, 1'b0);
        add(1'b1, 4'hC, 8'd9, 4'h4, R, 8'd1, 1'b0, 1'b0);
        add(1'b1, 4'hC, 8'd9, 4'h4, R, 8'd2, 1'b0, 1'b0);
        add(1'b1, 4'hC, 8'd9, 4'h4, W, 8'd2, 1'b0, 1'b0);
        add(1'b1, 4'hC, 8'd9, 4'h0, D, 8'd2, 1'b1, 1'b0);
        add(1'b1, 4'hC, 8'd9, 4'h0, I, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++)
            add(1'b1, 4'hC, 8'd9, 4'h8, R, 8'(k), 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd9, 4'h8, W, 8'd8, 1'b0, 1'b0);
        add(1'b1, 4'h0, 8'd9, 4'h0, D, 8'd8, 1'b1, 1'b0);
        add(1'b1, 4'h0, 8'd9, 4'h0, I, 8'd0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n   = vecs[i].rst_n;
            req     = vecs[i].req;
            cfg_len = vecs[i].len;
            #1;
            chk($sformatf("row%0d", i), {grant, state, count, done, abort},
                {vecs[i].grant, vecs[i].st, vecs[i].cnt, vecs[i].done, vecs[i].abort});
        end

        // Mid-slot reset: first move ptr to 2 with a requester-1 slot.
        @(negedge clk); req = 4'h2; cfg_len = 8'd1;
        @(negedge clk); req = 4'h0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); req = 4'h6; cfg_len = 8'd10;
        #1;
        chk("idle_before_slot", {grant, state, count, done, abort}, 16'h0000);
        begin
            int k;
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                if (state == R && count == 8'd5) break;
            end
            checks++;
            if (k >= 40) begin
                errors++;
                $display("FAIL wait_count5: state=%0d count=%0d after 40 cycles, expected RUN with count 5", state, count);
            end
        end
        #1;
        chk("run_at_5", {grant, state, count, done, abort}, {4'h4, R, 8'd5, 1'b0, 1'b0});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {grant, state, count, done, abort}, 16'h0000);
        @(posedge clk); #1;
        chk("reset_held", {grant, state, count, done, abort}, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("after_release", {grant, state, count, done, abort}, 16'h0000);
        @(negedge clk); #1;
        chk("ptr_reset_grant", {grant, state, count, done, abort}, {4'h2, R, 8'd0, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
